cr16_regfile: RTL and testbench
===============================

Name: cr16_regfile

Overview:
- Register file and processor status register (PSR) for the CR16 datapath.
- Sits directly upstream of cr16_alu: its two registered read ports drive the ALU I_A/I_B operands.
- Captures the ALU O_STATUS vector into the PSR and takes the ALU O_C result back on its write port.
- One write port, two read ports, write-first bypass, global stall via I_ENABLE.

Parameters:
- DATA_WIDTH, 16, register and operand width
- ADDR_WIDTH, 4, register address width; NUM_REGS = 2**ADDR_WIDTH (16)
- STATUS_WIDTH, 5, PSR/ALU status width

Ports:
- I_CLK  input  1  single clock, rising edge
- I_RESET  input  1  asynchronous, active-high reset
- I_ENABLE  input  1  global advance; 0 = stall (no state change)
- I_WE  input  1  register write enable
- I_WADDR  input  ADDR_WIDTH  write address
- I_WDATA  input  DATA_WIDTH  write data (ALU O_C or load data)
- I_RADDR_A  input  ADDR_WIDTH  read address, port A
- I_RADDR_B  input  ADDR_WIDTH  read address, port B
- O_DATA_A  output  DATA_WIDTH  registered operand A (to ALU I_A)
- O_DATA_B  output  DATA_WIDTH  registered operand B (to ALU I_B)
- I_PSR_WE  input  1  capture I_STATUS into PSR
- I_STATUS  input  STATUS_WIDTH  ALU O_STATUS
- O_PSR  output  STATUS_WIDTH  current PSR contents

Behaviour:
- Reset: asserting I_RESET immediately clears all NUM_REGS registers, O_DATA_A, O_DATA_B and O_PSR to 0, independent of the clock.
  - Applies mid-operation; any write in flight is discarded.
  - First edge after deassertion behaves normally.
- Write:
  - On a rising edge with I_ENABLE=1 and I_WE=1, regs[I_WADDR] <= I_WDATA.
  - With I_WE=0 or I_ENABLE=0, no register changes.
- Read:
  - 1-cycle latency. On a rising edge with I_ENABLE=1, O_DATA_A <= regs[I_RADDR_A] and O_DATA_B <= regs[I_RADDR_B].
  - Write-first bypass: if I_WE=1 and I_WADDR equals a read address in the same cycle, that port loads I_WDATA, not the stale value.
  - A and B may read the same address; both get identical data.
- Stall: with I_ENABLE=0, O_DATA_A, O_DATA_B and O_PSR hold; write and PSR-capture requests that cycle are dropped (not queued).
- PSR:
  - On a rising edge with I_ENABLE=1 and I_PSR_WE=1, O_PSR <= I_STATUS; otherwise it holds.
  - Bit map: [0] C carry, [1] L low/unsigned-compare, [2] F signed overflow, [3] Z zero, [4] N negative.
  - A register write and PSR capture in the same cycle are independent and both take effect.
- Widths: no arithmetic; addresses cover the full range 0..NUM_REGS-1 with no out-of-range case.

Optional Feature:
- Macro CR16_REGFILE_ZERO_R0_EN.
- Defined:
  - Register 0 is hardwired to 0; writes to address 0 are ignored.
  - Reads of address 0 return 0, including when a same-cycle write targets address 0 (no bypass for R0).
- Undefined: R0 is an ordinary register, fully writable and bypassed.

Decomposition:
- Shared package cr16_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, STATUS_WIDTH constants
  - PSR bit-index constants PSR_C=0, PSR_L=1, PSR_F=2, PSR_Z=3, PSR_N=4
  - ALU opcode constants (shared with cr16_alu)
- One sub-module is natural: cr16_psr, the STATUS_WIDTH enable/capture register with async reset, instantiated once.

Test Plan:
- Reset mid-run: write R5=0x1234, assert I_RESET between edges -> O_DATA_A, O_DATA_B, O_PSR go to 0 immediately; reading R5 after release -> 0x0000.
- Write then read: write R3=0xBEEF; next cycle I_RADDR_A=3 -> O_DATA_A=0xBEEF one edge later; O_DATA_B (I_RADDR_B=4, unwritten) = 0x0000.
- Bypass: same cycle I_WE=1, I_WADDR=7, I_WDATA=0x00FF, I_RADDR_A=7, I_RADDR_B=7 -> after that edge O_DATA_A=O_DATA_B=0x00FF.
- Stall: I_ENABLE=0 with I_WE=1, I_WADDR=2, I_WDATA=0xAAAA, I_PSR_WE=1, I_STATUS=5'b11111 -> outputs unchanged; later read of R2 returns its prior value and O_PSR is unchanged.
- PSR capture through the ALU path: ALU ADDU 0xFFFF+0x0001 gives O_C=0x0000 with status Z and C set; I_STATUS=5'b01001, I_PSR_WE=1 -> O_PSR=5'b01001 next edge and holds while I_PSR_WE=0.
- Macro on (CR16_REGFILE_ZERO_R0_EN): write R0=0x5555 with bypass read of R0 -> O_DATA_A=0x0000 that cycle and afterwards.
- Macro off: the same stimulus -> O_DATA_A=0x5555.

Source files
------------

// File: rtl/cr16_pkg.sv
// Shared CR16 datapath constants: widths, PSR bit positions and ALU opcodes.
package cr16_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int ADDR_WIDTH   = 4;
    localparam int STATUS_WIDTH = 5;
    localparam int NUM_REGS     = 2 ** ADDR_WIDTH;

    // PSR bit indices, matching the cr16_alu O_STATUS layout
    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_ADDU = 4'h1;
    localparam logic [3:0] ALU_ADDC = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h3;
    localparam logic [3:0] ALU_SUBC = 4'h4;
    localparam logic [3:0] ALU_CMP  = 4'h5;
    localparam logic [3:0] ALU_AND  = 4'h6;
    localparam logic [3:0] ALU_OR   = 4'h7;
    localparam logic [3:0] ALU_XOR  = 4'h8;
    localparam logic [3:0] ALU_MOV  = 4'h9;
    localparam logic [3:0] ALU_LSH  = 4'hA;
    localparam logic [3:0] ALU_ASH  = 4'hB;

endpackage

// File: rtl/cr16_psr.sv
// Processor status register: loads the ALU status vector when enabled, else holds.
module cr16_psr
    import cr16_pkg::*;
#(
    parameter int WIDTH = STATUS_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] status,
    output logic [WIDTH-1:0] psr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psr <= '0;
        end else if (load) begin
            psr <= status;
        end
    end

endmodule

// File: rtl/cr16_regfile.sv
// CR16 register file: one write port, two registered write-first read ports, PSR.
// Optional macro CR16_REGFILE_ZERO_R0_EN hardwires R0 to zero.
module cr16_regfile
    import cr16_pkg::*;
#(
    parameter int DATA_WIDTH   = cr16_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH   = cr16_pkg::ADDR_WIDTH,
    parameter int STATUS_WIDTH = cr16_pkg::STATUS_WIDTH
) (
    input  logic                    I_CLK,
    input  logic                    I_RESET,
    input  logic                    I_ENABLE,
    input  logic                    I_WE,
    input  logic [ADDR_WIDTH-1:0]   I_WADDR,
    input  logic [DATA_WIDTH-1:0]   I_WDATA,
    input  logic [ADDR_WIDTH-1:0]   I_RADDR_A,
    input  logic [ADDR_WIDTH-1:0]   I_RADDR_B,
    output logic [DATA_WIDTH-1:0]   O_DATA_A,
    output logic [DATA_WIDTH-1:0]   O_DATA_B,
    input  logic                    I_PSR_WE,
    input  logic [STATUS_WIDTH-1:0] I_STATUS,
    output logic [STATUS_WIDTH-1:0] O_PSR
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

`ifdef CR16_REGFILE_ZERO_R0_EN
    localparam bit ZERO_R0 = 1'b1;
`else
    localparam bit ZERO_R0 = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    always_comb begin
        wr_ok = I_WE && !(ZERO_R0 && (I_WADDR == '0));
    end

    // Write-first: a same-cycle write to the read address wins over the array
    always_comb begin
        rd_a = regs[I_RADDR_A];
        rd_b = regs[I_RADDR_B];
        if (wr_ok && (I_WADDR == I_RADDR_A)) rd_a = I_WDATA;
        if (wr_ok && (I_WADDR == I_RADDR_B)) rd_b = I_WDATA;
        if (ZERO_R0 && (I_RADDR_A == '0)) rd_a = '0;
        if (ZERO_R0 && (I_RADDR_B == '0)) rd_b = '0;
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (I_ENABLE && wr_ok) begin
            regs[I_WADDR] <= I_WDATA;
        end
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            O_DATA_A <= '0;
            O_DATA_B <= '0;
        end else if (I_ENABLE) begin
            O_DATA_A <= rd_a;
            O_DATA_B <= rd_b;
        end
    end

    cr16_psr #(
        .WIDTH (STATUS_WIDTH)
    ) u_psr (
        .clk    (I_CLK),
        .rst    (I_RESET),
        .load   (I_ENABLE & I_PSR_WE),
        .status (I_STATUS),
        .psr    (O_PSR)
    );

endmodule

// File: tb/tb_cr16_regfile.sv
// Self-checking bench for cr16_regfile: directed cases plus randomized traffic vs a reference model.
module tb_cr16_regfile;

`ifdef CR16_REGFILE_ZERO_R0_EN
    localparam bit ZERO_R0 = 1'b1;
`else
    localparam bit ZERO_R0 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [3:0]  raddr_a;
    logic [3:0]  raddr_b;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic        psr_we;
    logic [4:0]  status;
    logic [4:0]  psr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_regs [16];
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [4:0]  m_psr;

    always #5 clk = ~clk;

    cr16_regfile dut (
        .I_CLK     (clk),
        .I_RESET   (rst),
        .I_ENABLE  (en),
        .I_WE      (we),
        .I_WADDR   (waddr),
        .I_WDATA   (wdata),
        .I_RADDR_A (raddr_a),
        .I_RADDR_B (raddr_b),
        .O_DATA_A  (data_a),
        .O_DATA_B  (data_b),
        .I_PSR_WE  (psr_we),
        .I_STATUS  (status),
        .O_PSR     (psr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [3:0] a);
        if (ZERO_R0 && a == 4'd0) return 16'h0000;
        if (we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        m_a   = 16'h0;
        m_b   = 16'h0;
        m_psr = 5'h0;
    endtask

    // One clock edge: advance the model with the inputs held across it, then compare.
    task automatic step(input string tag);
        logic [15:0] na, nb;
        @(posedge clk);
        if (en) begin
            na = m_read(raddr_a);
            nb = m_read(raddr_b);
            if (we && !(ZERO_R0 && waddr == 4'd0)) m_regs[waddr] = wdata;
            if (psr_we) m_psr = status;
            m_a = na;
            m_b = nb;
        end
        #1;
        check({tag, ".a"},   {16'h0, data_a}, {16'h0, m_a});
        check({tag, ".b"},   {16'h0, data_b}, {16'h0, m_b});
        check({tag, ".psr"}, {27'h0, psr},    {27'h0, m_psr});
    endtask

    task automatic idle();
        en = 1'b1; we = 1'b0; psr_we = 1'b0;
        waddr = 4'd0; wdata = 16'h0; status = 5'h0;
        raddr_a = 4'd0; raddr_b = 4'd0;
    endtask

    initial begin
        logic [16:0] sum;
        logic [4:0]  alu_status;

        idle();
        rst = 1'b1;
        m_clear();
        #12;
        check("reset.a",   {16'h0, data_a}, 32'h0);
        check("reset.b",   {16'h0, data_b}, 32'h0);
        check("reset.psr", {27'h0, psr},    32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Mid-run reset discards state immediately
        we = 1'b1; waddr = 4'd5; wdata = 16'h1234; raddr_a = 4'd5; raddr_b = 4'd5;
        psr_we = 1'b1; status = 5'b10101;
        step("r5_wr");
        check("r5_wr.const", {16'h0, data_a}, 32'h1234);
        idle();
        #3 rst = 1'b1;
        #1;
        check("midrst.a",   {16'h0, data_a}, 32'h0);
        check("midrst.b",   {16'h0, data_b}, 32'h0);
        check("midrst.psr", {27'h0, psr},    32'h0);
        m_clear();
        #1 rst = 1'b0;
        raddr_a = 4'd5; raddr_b = 4'd5;
        step("r5_after_rst");
        check("r5_after_rst.const", {16'h0, data_a}, 32'h0);

        // Write then read
        idle(); we = 1'b1; waddr = 4'd3; wdata = 16'hBEEF;
        step("r3_wr");
        idle(); raddr_a = 4'd3; raddr_b = 4'd4;
        step("r3_rd");
        check("r3_rd.const", {16'h0, data_a}, 32'hBEEF);
        check("r4_rd.const", {16'h0, data_b}, 32'h0);

        // Bypass on both ports
        idle(); we = 1'b1; waddr = 4'd7; wdata = 16'h00FF; raddr_a = 4'd7; raddr_b = 4'd7;
        step("bypass");
        check("bypass.const", {16'h0, data_b}, 32'h00FF);

        // Stall drops write and PSR capture
        idle(); we = 1'b1; waddr = 4'd2; wdata = 16'h1111; raddr_a = 4'd3;
        step("r2_pre");
        idle(); en = 1'b0; we = 1'b1; waddr = 4'd2; wdata = 16'hAAAA;
        psr_we = 1'b1; status = 5'b11111; raddr_a = 4'd2; raddr_b = 4'd2;
        step("stall");
        check("stall.hold", {16'h0, data_a}, 32'hBEEF);
        idle(); raddr_a = 4'd2;
        step("r2_post");
        check("r2_post.const", {16'h0, data_a}, 32'h1111);

        // PSR from an ADDU 0xFFFF + 0x0001: result 0, carry out
        sum = 17'h0FFFF + 17'h00001;
        alu_status = '0;
        alu_status[0] = sum[16];
        alu_status[3] = (sum[15:0] == 16'h0);
        alu_status[4] = sum[15];
        idle(); psr_we = 1'b1; status = alu_status;
        step("psr_cap");
        check("psr_cap.const", {27'h0, psr}, 32'h09);
        idle(); status = 5'b10010;
        step("psr_hold");
        step("psr_hold2");

        // R0 write with bypass read
        idle(); we = 1'b1; waddr = 4'd0; wdata = 16'h5555; raddr_a = 4'd0;
        step("r0_wr");
        check("r0_wr.const", {16'h0, data_a}, ZERO_R0 ? 32'h0 : 32'h5555);
        idle(); raddr_a = 4'd0;
        step("r0_rd");
        check("r0_rd.const", {16'h0, data_a}, ZERO_R0 ? 32'h0 : 32'h5555);

        // Randomized traffic, with occasional asynchronous reset pulses
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            we      = $urandom_range(0, 1);
            waddr   = 4'($urandom_range(0, 15));
            wdata   = 16'($urandom);
            raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : 4'($urandom_range(0, 15));
            psr_we  = $urandom_range(0, 1);
            status  = 5'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                #1;
                check("rnd_rst.a", {16'h0, data_a}, 32'h0);
                m_clear();
                #1 rst = 1'b0;
            end
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
